alu_flags_retire: RTL
=====================

Name: alu_flags_retire

Overview:
- Downstream stage of the bitwise/arithmetic N-bit ALU units.
- Accepts each ALU result plus its flags_n_z_v_c through a valid/ready handshake and buffers it in a 2-entry skid FIFO.
- Retires results to writeback and updates the architectural NZVC status register on retirement.
- Evaluates a 4-bit condition code against the status register for branch/predication logic.

Parameters:
- N, 8, ALU data width in bits (N >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result/flags present.
- in_ready  output  1  stage can accept an entry this cycle.
- in_result  input  N  ALU out value.
- in_flags_n_z_v_c  input  4  ALU flags: [3]=N, [2]=Z, [1]=V, [0]=C.
- in_set_flags  input  1  entry updates the status register on retire.
- out_valid  output  1  head entry available for writeback.
- out_ready  input  1  writeback consumes head.
- out_result  output  N  head entry result.
- flags_n_z_v_c  output  4  architectural status register, same bit order.
- sticky_v  output  1  sticky overflow flag.
- clr_sticky  input  1  clear sticky_v.
- cond_sel  input  4  condition code select.
- cond_true  output  1  condition evaluated on flags_n_z_v_c.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Reset values (reset_n=0, immediate):
  - FIFO count=0, out_valid=0, in_ready=1, out_result=0.
  - flags_n_z_v_c=4'b0000, sticky_v=0.
  - In-flight entries are discarded when reset asserts mid-operation.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != 2), derived from registered count only. It has no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_result, and the head's flags and set_flags, come from registered storage.
- Latency: an entry pushed at edge k is visible on out_valid/out_result after edge k. Minimum 1 cycle.
- FIFO count transitions:
  - push only: +1.
  - pop only: -1.
  - push+pop at count=1: count stays 1, and the new entry becomes head after the edge.
  - push+pop at count=0 is impossible because out_valid=0.
  - push at count=2 is impossible because in_ready=0.
  - in_valid while in_ready=0 is ignored. The source holds its data.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Status update at the pop edge, if head set_flags=1:
  - flags_n_z_v_c <= head flags.
  - Otherwise the status register holds.
  - Status never changes on push.
- sticky_v:
  - Set at a pop edge where head set_flags=1 and head V=1.
  - Cleared at an edge with clr_sticky=1.
  - Simultaneous set and clear: set wins.
- cond_true is combinational from cond_sel and the registered flags:
  - 0 EQ: Z.
  - 1 NE: !Z.
  - 2 CS: C.
  - 3 CC: !C.
  - 4 MI: N.
  - 5 PL: !N.
  - 6 VS: V.
  - 7 VC: !V.
  - 8 HI: C&!Z.
  - 9 LS: !C|Z.
  - 10 GE: N==V.
  - 11 LT: N!=V.
  - 12 GT: !Z&(N==V).
  - 13 LE: Z|(N!=V).
  - 14 AL: 1.
  - 15 NV: 0.
- Flags pass through unmodified. No arithmetic is performed on the result.

Test Plan:
- Reset check: assert reset_n=0 mid-stream with 2 entries queued -> out_valid=0, in_ready=1, flags=0000, sticky_v=0, cond_true(EQ)=0 immediately, without waiting for a clock edge.
- Single pass-through, out_ready=1: push result=8'h0F, flags=0000, set_flags=1 -> next cycle out_valid=1, out_result=8'h0F. After the pop edge, flags=0000 and cond_sel=NE gives 1.
- Backpressure, out_ready=0: push 8'h01, 8'h02, 8'h03 -> in_ready drops after the 2nd push, the 3rd is held. Raise out_ready -> outputs 01, 02, 03 in order with none lost.
- Simultaneous push/pop at count=1, continuous in_valid=out_ready=1 over results 1..5 -> one result per cycle, in_ready never drops, output sequence 1,2,3,4,5.
- Flag gating: retire flags=0100 (set_flags=1), then flags=1010 (set_flags=0) -> status stays 0100. EQ=1, LE=1, GT=0.
- Sticky and conditions:
  - Retire flags=0010 (set_flags=1) -> sticky_v=1, VS=1, LT=1.
  - Retire flags=0000 -> sticky_v stays 1.
  - clr_sticky in the same cycle as a retire of V=1 -> sticky_v stays 1.
  - clr_sticky alone -> sticky_v=0.

Source files
------------

// File: rtl/alu_flags_retire.sv
// rtl/alu_flags_retire.sv - ALU result retire stage with skid FIFO, NZVC status and condition evaluation
//
// Purpose: buffers ALU results and their flags in a 2-entry FIFO, retires them
// to writeback, updates the NZVC status register on retirement of entries that
// set flags, tracks a sticky overflow bit, and evaluates a condition code.
//
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_ready depends on stored count only
//   in_result            ALU result (N bits)
//   in_flags_n_z_v_c     ALU flags [3]=N [2]=Z [1]=V [0]=C
//   in_set_flags         entry updates the status register when retired
//   out_valid/out_ready  writeback handshake for the head entry
//   out_result           head entry result
//   flags_n_z_v_c        architectural status register
//   sticky_v, clr_sticky sticky overflow flag and its clear
//   cond_sel, cond_true  condition select and its evaluation on the status register

module alu_flags_retire #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_result,
   input  logic [3:0]   in_flags_n_z_v_c,
   input  logic         in_set_flags,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [3:0]   flags_n_z_v_c,
   output logic         sticky_v,
   input  logic         clr_sticky,
   input  logic [3:0]   cond_sel,
   output logic         cond_true
);

   logic [N-1:0] mem_result [2];
   logic [3:0]   mem_flags  [2];
   logic [1:0]   mem_set;
   logic         rd_ptr;
   logic         wr_ptr;
   logic [1:0]   count;
   logic         push;
   logic         pop;
   logic [3:0]   head_flags;
   logic         head_set;

   // Ready comes from the stored count alone so no path exists from out_ready.
   assign in_ready   = (count != 2'd2);
   assign out_valid  = (count != 2'd0);
   assign push       = in_valid & in_ready;
   assign pop        = out_valid & out_ready;
   assign out_result = mem_result[rd_ptr];
   assign head_flags = mem_flags[rd_ptr];
   assign head_set   = mem_set[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_result[0] <= '0;
         mem_result[1] <= '0;
         mem_flags[0]  <= 4'b0000;
         mem_flags[1]  <= 4'b0000;
         mem_set       <= 2'b00;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         count         <= 2'd0;
      end else begin
         if (push) begin
            mem_result[wr_ptr] <= in_result;
            mem_flags[wr_ptr]  <= in_flags_n_z_v_c;
            mem_set[wr_ptr]    <= in_set_flags;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         // Push and pop together leave the count unchanged.
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Status only changes when a flag-setting entry leaves the FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_n_z_v_c <= 4'b0000;
         sticky_v      <= 1'b0;
      end else begin
         if (pop && head_set) begin
            flags_n_z_v_c <= head_flags;
         end
         // A retiring overflow beats a simultaneous clear.
         if (pop && head_set && head_flags[1]) begin
            sticky_v <= 1'b1;
         end else if (clr_sticky) begin
            sticky_v <= 1'b0;
         end
      end
   end

   logic f_n, f_z, f_v, f_c;
   assign {f_n, f_z, f_v, f_c} = flags_n_z_v_c;

   always_comb begin
      cond_true = 1'b0;
      case (cond_sel)
         4'd0:    cond_true = f_z;
         4'd1:    cond_true = ~f_z;
         4'd2:    cond_true = f_c;
         4'd3:    cond_true = ~f_c;
         4'd4:    cond_true = f_n;
         4'd5:    cond_true = ~f_n;
         4'd6:    cond_true = f_v;
         4'd7:    cond_true = ~f_v;
         4'd8:    cond_true = f_c & ~f_z;
         4'd9:    cond_true = ~f_c | f_z;
         4'd10:   cond_true = (f_n == f_v);
         4'd11:   cond_true = (f_n != f_v);
         4'd12:   cond_true = ~f_z & (f_n == f_v);
         4'd13:   cond_true = f_z | (f_n != f_v);
         4'd14:   cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule
